// File: rtl/syn_fifo.sv
// Single-clock FIFO, DATA_WIDTH x FIFO_SIZE, with registered read data and full/empty/overflow/underflow status.
// Latency: a write is readable from the edge after it lands; rdata updates on the edge that performs the read.
// Backpressure: a write while full or a read while empty is dropped and flagged with a one-cycle error pulse.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   wr_en      write request; wdata sampled with it
//   wdata      write data word
//   full       FIFO holds FIFO_SIZE words (combinational from pointers)
//   overflow   registered pulse: the previous write was rejected
//   rd_en      read request
//   rdata      registered read data, holds when no read occurs
//   empty      FIFO holds zero words (combinational from pointers)
//   underflow  registered pulse: the previous read was rejected
module syn_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16,   // power of two, >= 2
  localparam int PTR_WIDTH = $clog2(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the addresses coincide.
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_addr;
  logic [PTR_WIDTH-1:0]  rd_addr;
  logic                  wr_ok;
  logic                  rd_ok;

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];

  assign wr_addr = wr_ptr[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr[PTR_WIDTH-1:0];

  // Flags depend only on registered pointers, so there is no combinational
  // path from the request inputs to full/empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_addr == rd_addr) && (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);

  // Acceptance uses the pre-edge flags: a simultaneous read on a full FIFO
  // does not free a slot for the same-edge write, and vice versa when empty.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage is deliberately not reset; stale contents are unreachable
  // because the pointers restart equal.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      rdata  <= '0;
    end else if (rd_ok) begin
      rd_ptr <= rd_ptr + PTR_ONE;
      rdata  <= mem[rd_addr];
    end
  end

  // Error pulses re-evaluate every cycle, so a run of rejected requests
  // keeps the corresponding flag high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_syn_fifo.sv
module tb_syn_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          full;
  logic          overflow;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          underflow;

  syn_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .full      (full),
    .overflow  (overflow),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .empty     (empty),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of stored words plus the expected
  // registered outputs.
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_rdata;
  logic          exp_ovf;
  logic          exp_udf;
  int            passed;
  int            total;
  int            cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s c%0d rdata", tag, cyc), {24'd0, rdata}, {24'd0, exp_rdata});
    chk($sformatf("%s c%0d empty", tag, cyc), {31'd0, empty}, {31'd0, (q.size() == 0)});
    chk($sformatf("%s c%0d full", tag, cyc), {31'd0, full}, {31'd0, (q.size() == DEPTH)});
    chk($sformatf("%s c%0d overflow", tag, cyc), {31'd0, overflow}, {31'd0, exp_ovf});
    chk($sformatf("%s c%0d underflow", tag, cyc), {31'd0, underflow}, {31'd0, exp_udf});
  endtask

  // One clock cycle with the given requests; model updated from the
  // pre-edge occupancy, outputs checked 1 ns after the edge.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    bit was_full;
    bit was_empty;
    wr_en = w;
    rd_en = r;
    wdata = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_ovf = w && was_full;
    exp_udf = r && was_empty;
    if (r && !was_empty) exp_rdata = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    cyc = cyc + 1;
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    rst    = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wdata  = '0;
    model_reset();

    // Reset state
    #12;
    check_all("RESET");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // WR_RD: 16 random writes then 16 reads
    for (int i = 0; i < DEPTH; i++) cycle("WR_RD_W", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < DEPTH; i++) cycle("WR_RD_R", 1'b0, 1'b1, '0);

    // FULL then OVERFLOW: 17 writes, 17th rejected, pulse then clears
    for (int i = 0; i < DEPTH; i++) cycle("FULL", 1'b1, 1'b0, DW'($urandom));
    cycle("OVF", 1'b1, 1'b0, 8'hEE);
    cycle("OVF_CLR", 1'b0, 1'b0, '0);
    // Continuous rejected writes hold overflow high
    cycle("OVF_HOLD", 1'b1, 1'b0, 8'h11);
    cycle("OVF_HOLD", 1'b1, 1'b0, 8'h22);

    // Full with simultaneous read and write: oldest read, write dropped
    cycle("FULL_WR_RD", 1'b1, 1'b1, 8'h77);

    // UNDERFLOW: drain remaining 15, then one extra read
    for (int i = 0; i < DEPTH - 1; i++) cycle("DRAIN", 1'b0, 1'b1, '0);
    cycle("UDF", 1'b0, 1'b1, '0);
    cycle("UDF_CLR", 1'b0, 1'b0, '0);

    // Empty with simultaneous read and write: write lands, read rejected
    cycle("EMPTY_WR_RD", 1'b1, 1'b1, 8'h5A);
    cycle("EMPTY_WR_RD_RD", 1'b0, 1'b1, '0);

    // CONCURRENT: random request mix with random idle gaps
    for (int i = 0; i < 300; i++) begin
      cycle("CONC", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) cycle("CONC_GAP", 1'b0, 1'b0, '0);
    end
    // Biased phases so both full and empty boundaries are crossed
    for (int i = 0; i < 60; i++)
      cycle("CONC_FILL", 1'b1, ($urandom_range(0, 3) == 0), DW'($urandom));
    for (int i = 0; i < 60; i++)
      cycle("CONC_DRAIN", ($urandom_range(0, 3) == 0), 1'b1, DW'($urandom));

    // Mid-stream asynchronous reset
    cycle("PRE_RST", 1'b1, 1'b0, 8'hA5);
    cycle("PRE_RST", 1'b1, 1'b0, 8'hC3);
    cycle("PRE_RST", 1'b0, 1'b1, '0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("ASYNC_RST");
    @(posedge clk);
    #1;
    check_all("RST_HOLD");
    rst = 1'b1;
    cycle("POST_RST_W", 1'b1, 1'b0, 8'h3C);
    cycle("POST_RST_R", 1'b0, 1'b1, '0);
    cycle("POST_RST_IDLE", 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/syn_fifo.md
Name: syn_fifo

Overview:
- Single-clock synchronous FIFO, DATA_WIDTH x FIFO_SIZE, with registered read data.
- Provides full/empty status and overflow/underflow error pulses.
- Used as a generic buffer between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of the write and read data words.
- FIFO_SIZE, 16, depth in words; must be a power of two, >= 2.
- PTR_WIDTH, $clog2(FIFO_SIZE), address width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset.
- wr_en  input  1  write request.
- wdata  input  DATA_WIDTH  write data, sampled with wr_en.
- full  output  1  FIFO holds FIFO_SIZE words.
- overflow  output  1  one-cycle pulse: the previous write was rejected.
- rd_en  input  1  read request.
- rdata  output  DATA_WIDTH  registered read data.
- empty  output  1  FIFO holds zero words.
- underflow  output  1  one-cycle pulse: the previous read was rejected.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Port order for positional instantiation is exactly: clk, rst, wr_en, wdata, full, overflow, rd_en, rdata, empty, underflow.
- Reset (rst low) takes effect immediately and holds while low:
  - write and read pointers clear to 0 (each pointer is PTR_WIDTH bits plus one wrap bit);
  - rdata = 0, overflow = 0, underflow = 0;
  - empty = 1, full = 0;
  - storage array is not cleared.
- Reset mid-operation discards all contents; the first write after release goes to address 0.
- Write:
  - At a rising edge with wr_en = 1 and full = 0, wdata is stored at mem[wr_ptr] and wr_ptr increments.
  - The address wraps modulo FIFO_SIZE and the wrap bit toggles on wrap.
- Read:
  - At a rising edge with rd_en = 1 and empty = 0, mem[rd_ptr] is loaded into rdata and rd_ptr increments with the same wrap rules.
  - rdata is valid from the edge that performs the read (1-cycle latency from the sampled rd_en).
  - rdata holds its value when no read occurs.
- Status flags are combinational from the pointers:
  - empty = pointers fully equal, including the wrap bit;
  - full = addresses equal and wrap bits differ.
- Overflow:
  - At an edge where wr_en = 1 and full = 1, the write is dropped: memory and wr_ptr are unchanged.
  - overflow is registered 1 for the following cycle, else 0.
  - It re-pulses on every rejected write cycle, so continuous rejected writes hold it high.
- Underflow:
  - At an edge where rd_en = 1 and empty = 1, the read is dropped: rd_ptr and rdata are unchanged.
  - underflow is registered 1 for the following cycle.
- Simultaneous wr_en and rd_en, both sides allowed: both occur in the same edge; occupancy is unchanged and the flags are unchanged.
- Simultaneous, FIFO full:
  - the read succeeds;
  - the write is rejected because full is evaluated before the edge, and overflow pulses;
  - after the edge the FIFO holds FIFO_SIZE-1 words.
- Simultaneous, FIFO empty:
  - the write succeeds;
  - the read is rejected and underflow pulses;
  - after the edge the FIFO holds 1 word, empty = 0.
- Ordering is strict FIFO: words are read in write order with no loss or duplication across pointer wrap-around.
- There are no combinational paths from wr_en/rd_en to full/empty; flags change only after a clock edge or reset.

Test Plan:
- WR_RD:
  - Stimulus: reset, then write 16 random words on consecutive cycles, then read 16.
  - Required: rdata returns the same 16 values in order, one per cycle after each read edge.
  - Required: empty = 1 at end; overflow and underflow never assert.
- FULL: write 16 words from empty -> full rises at the edge of the 16th write; empty = 0; overflow stays 0.
- OVERFLOW:
  - Stimulus: write 17 words from empty.
  - Required: the 17th write is dropped and overflow = 1 for exactly one cycle; full remains 1.
  - Required: a subsequent read of 16 words returns the first 16 values only.
- UNDERFLOW:
  - Stimulus: write 16, then read 17.
  - Required: empty rises after the 16th read.
  - Required: the 17th read pulses underflow for one cycle with rdata holding the 16th value.
- CONCURRENT:
  - Stimulus: 20 single writes and 20 single reads with random 5-20 ns gaps, reads starting once empty = 0.
  - Required: all data is read back in order; no false overflow/underflow while 0 < occupancy < 16.
- Edge cases:
  - With the FIFO full, assert wr_en and rd_en together -> the oldest word is read, overflow pulses, occupancy becomes 15.
  - With the FIFO empty, do the same -> underflow pulses, occupancy becomes 1.
  - Assert rst low mid-stream -> empty = 1, rdata = 0 immediately, without waiting for a clock edge.
